muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit; replaces the separate multiplier and divisor in the CPU datapath.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_unit_div_step.sv | 25 ++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes, FSM states, opcode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULT  = 2'b00;
  localparam op_t OP_MULTU = 2'b01;
  localparam op_t OP_DIV   = 2'b10;
  localparam op_t OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic isDivOp(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the datapath and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the unit is not busy.
//   master: drives start/op/a/b/cancel, receives busy/done/div_by_zero/hi/lo
//   slave : the multiply/divide unit itself
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//   remIn/divisor/dividendBit -> remOut (new partial remainder), quotBit (1 when subtracted)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividendBit,
  output logic [WIDTH-1:0] remOut,
  output logic             quotBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // remIn < divisor holds every step, so the shifted value needs one extra bit
  // and whichever remainder is kept fits back into WIDTH bits.
  assign shifted = {remIn, dividendBit};
  assign trial   = shifted - {1'b0, divisor};
  assign quotBit = (shifted >= {1'b0, divisor});
  assign remOut  = quotBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results, one bit per cycle.
// Latency: done WIDTH+3 cycles after start (2 cycles for divide by zero).
// Backpressure: start ignored while busy; cancel aborts with no done and no result update.
//   clock/reset : rising-edge clock, asynchronous active-low reset
//   bus (slave) : start/op/a/b/cancel in; busy/done/div_by_zero/hi/lo out
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, stateNext;
  op_t                opReg;
  logic [WIDTH-1:0]   aReg, bReg, hiReg, loReg;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic               negQ, negR, doneReg, dbzReg;

  logic               divOp, signedOp, bZero, quotBit;
  logic [WIDTH-1:0]   aMag, bMag, remStep, quotFix, remFix;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext, divNext, prodFix;

  assign divOp    = isDivOp(opReg);
  assign signedOp = isSignedOp(opReg);
  assign bZero    = (bReg == '0);

  // aReg/bReg still hold the raw operands while in PREP.
  assign aMag = (signedOp && aReg[WIDTH-1]) ? -aReg : aReg;
  assign bMag = (signedOp && bReg[WIDTH-1]) ? -bReg : bReg;

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & bReg};
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  div_step #(.WIDTH(WIDTH)) step (
    .remIn      (acc[2*WIDTH-1:WIDTH]),
    .divisor    (bReg),
    .dividendBit(acc[WIDTH-1]),
    .remOut     (remStep),
    .quotBit    (quotBit)
  );
  assign divNext = {remStep, acc[WIDTH-2:0], quotBit};

  // Sign correction: remainder follows the dividend so the quotient truncates toward zero.
  assign prodFix = negQ ? -acc : acc;
  assign quotFix = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix  = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: stateNext = bus.start ? PREP : IDLE;
      PREP: begin
        if (bus.cancel)          stateNext = IDLE;
        else if (divOp && bZero) stateNext = DONE;
        else                     stateNext = RUN;
      end
      RUN: begin
        if (bus.cancel)                 stateNext = IDLE;
        else if (count == CNT_W'(1))    stateNext = FIX;
      end
      FIX:     stateNext = bus.cancel ? IDLE : DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opReg   <= '0;
      aReg    <= '0;
      bReg    <= '0;
      acc     <= '0;
      count   <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
    end else begin
      doneReg <= (stateNext == DONE);
      dbzReg  <= (state == PREP) && (stateNext == DONE);
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            opReg <= bus.op;
            aReg  <= bus.a;
            bReg  <= bus.b;
          end
        end
        PREP: begin
          aReg  <= aMag;
          bReg  <= bMag;
          acc   <= {{WIDTH{1'b0}}, aMag};
          count <= CNT_W'(WIDTH);
          negQ  <= signedOp & (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
          negR  <= signedOp & aReg[WIDTH-1];
          if (stateNext == DONE) begin
            hiReg <= aReg;
            loReg <= '1;
          end
        end
        RUN: begin
          count <= count - CNT_W'(1);
          acc   <= divOp ? divNext : mulNext;
        end
        FIX: begin
          if (stateNext == DONE) begin
            hiReg <= divOp ? remFix  : prodFix[2*WIDTH-1:WIDTH];
            loReg <= divOp ? quotFix : prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == PREP) || (state == RUN) || (state == FIX);
  assign bus.done        = doneReg;
  assign bus.div_by_zero = dbzReg;
  assign bus.hi          = hiReg;
  assign bus.lo          = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed WIDTH=32 cases plus randomized WIDTH=8 ops against an arithmetic model.
// Latency: cycle counts measured from the start cycle.
// Backpressure: start held while busy, cancel and reset mid-operation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic resetN;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.WIDTH(32)) bus32 ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clock(clock), .reset(resetN), .bus(bus32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clock(clock), .reset(resetN), .bus(bus8.slave));

  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit n, input logic s, input op_t o, input logic [63:0] x, input logic [63:0] y);
    if (n) begin
      bus8.start = s; bus8.op = o; bus8.a = x[7:0]; bus8.b = y[7:0];
    end else begin
      bus32.start = s; bus32.op = o; bus32.a = x[31:0]; bus32.b = y[31:0];
    end
  endtask

  task automatic sample(input bit n, output logic bsy, output logic dn, output logic dz,
                        output logic [63:0] h, output logic [63:0] l);
    if (n) begin
      bsy = bus8.busy; dn = bus8.done; dz = bus8.div_by_zero;
      h = 64'(bus8.hi); l = 64'(bus8.lo);
    end else begin
      bsy = bus32.busy; dn = bus32.done; dz = bus32.div_by_zero;
      h = 64'(bus32.hi); l = 64'(bus32.lo);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic on w-bit operands.
  function automatic void model(input op_t o, input logic [63:0] x, input logic [63:0] y, input int w,
                                output logic [63:0] hi, output logic [63:0] lo, output logic dz);
    longint unsigned mask, ux, uy, p;
    longint sx, sy;
    mask = (64'd1 << w) - 64'd1;
    ux = x & mask;
    uy = y & mask;
    sx = longint'(ux << (64 - w)) >>> (64 - w);
    sy = longint'(uy << (64 - w)) >>> (64 - w);
    dz = 1'b0; hi = '0; lo = '0;
    if ((o == OP_DIV || o == OP_DIVU) && uy == 0) begin
      dz = 1'b1; hi = ux; lo = mask;
    end else begin
      case (o)
        OP_MULT:  begin p = $unsigned(sx * sy); hi = (p >> w) & mask; lo = p & mask; end
        OP_MULTU: begin p = ux * uy;            hi = (p >> w) & mask; lo = p & mask; end
        OP_DIV:   begin lo = $unsigned(sx / sy) & mask; hi = $unsigned(sx % sy) & mask; end
        default:  begin lo = (ux / uy) & mask; hi = (ux % uy) & mask; end
      endcase
    end
  endfunction

  // Issues one op (now=1: start is raised in the current cycle, e.g. the DONE cycle),
  // scrambles op/a/b while busy, optionally holds start high in cycles 3..20,
  // and checks latency, busy, flag and results.
  task automatic runOp(input string tag, input bit n, input bit now, input bit holdStart,
                       input op_t o, input logic [63:0] x, input logic [63:0] y, input int expLat,
                       input logic [63:0] expHi, input logic [63:0] expLo, input logic expDz);
    int lat;
    logic bsy, dn, dz;
    logic [63:0] h, l;
    bsy = 1'b0; dn = 1'b0; dz = 1'b0; h = '0; l = '0;
    if (!now) begin
      @(posedge clock); #1;
    end
    drive(n, 1'b1, o, x, y);
    lat = -1;
    for (int k = 0; k < expLat + 20; k++) begin
      if (k > 0) begin
        @(negedge clock);
        sample(n, bsy, dn, dz, h, l);
        if (k == 1) checkEq({tag, "_busy1"}, 64'(bsy), 64'd1);
        if (dn) begin
          lat = k;
          break;
        end
      end
      @(posedge clock); #1;
      drive(n, holdStart && (k + 1 >= 3) && (k + 1 <= 20), op_t'($urandom_range(0, 3)),
            {$urandom, $urandom}, {$urandom, $urandom});
    end
    checkEq({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkEq({tag, "_busyDone"}, 64'(bsy), 64'd0);
    checkEq({tag, "_dz"}, 64'(dz), 64'(expDz));
    checkEq({tag, "_hi"}, h, expHi);
    checkEq({tag, "_lo"}, l, expLo);
    drive(n, 1'b0, o, x, y);
  endtask

  initial begin
    logic bsy, dn, dz, sawDone, sawBusy;
    logic [63:0] h, l, eh, el, x, y;
    logic ed;
    int lat;

    resetN = 1'b0;
    drive(1'b0, 1'b0, OP_MULT, '0, '0);
    drive(1'b1, 1'b0, OP_MULT, '0, '0);
    bus32.cancel = 1'b0;
    bus8.cancel  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    sample(1'b0, bsy, dn, dz, h, l);
    checkEq("rst_busy", 64'(bsy), 64'd0);
    checkEq("rst_done", 64'(dn), 64'd0);
    checkEq("rst_dz", 64'(dz), 64'd0);
    checkEq("rst_hi", h, 64'd0);
    checkEq("rst_lo", l, 64'd0);
    @(posedge clock); #1;
    resetN = 1'b1;

    runOp("mult", 1'b0, 1'b0, 1'b0, OP_MULT, 32'hFFFF_FFFD, 32'd7, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("multu", 1'b0, 1'b0, 1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 32'hFFFF_FFFE, 32'h1, 1'b0);
    runOp("b2b", 1'b0, 1'b1, 1'b0, OP_MULT, 32'd6, 32'hFFFF_FFFE, 35, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);
    runOp("div", 1'b0, 1'b0, 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("divNegB", 1'b0, 1'b0, 1'b0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 35, 32'd1, 32'hFFFF_FFFD, 1'b0);
    runOp("divu", 1'b0, 1'b0, 1'b0, OP_DIVU, 32'd7, 32'd2, 35, 32'd1, 32'd3, 1'b0);
    runOp("divOvf", 1'b0, 1'b0, 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0, 32'h8000_0000, 1'b0);
    runOp("dz", 1'b0, 1'b0, 1'b0, OP_DIV, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);
    @(negedge clock);
    sample(1'b0, bsy, dn, dz, h, l);
    checkEq("dz_donePulse", 64'(dn), 64'd0);
    checkEq("dz_flagPulse", 64'(dz), 64'd0);
    runOp("dzu", 1'b0, 1'b0, 1'b0, OP_DIVU, 32'h8000_0000, 32'd0, 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    runOp("hold", 1'b0, 1'b0, 1'b1, OP_MULTU, 32'd1000, 32'd1000, 35, 32'd0, 32'd1000000, 1'b0);
    @(negedge clock);
    sample(1'b0, bsy, dn, dz, h, l);
    checkEq("hold_noRestart", 64'(bsy), 64'd0);

    // Cancel in cycle 10: busy drops in cycle 11, no done, prior result kept.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, OP_MULT, 64'd123, 64'd456);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, OP_MULT, '0, '0);
    repeat (9) begin
      @(posedge clock); #1;
    end
    bus32.cancel = 1'b1;
    @(negedge clock);
    sample(1'b0, bsy, dn, dz, h, l);
    checkEq("cancel_busy10", 64'(bsy), 64'd1);
    @(posedge clock); #1;
    bus32.cancel = 1'b0;
    sawDone = 1'b0; sawBusy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      sample(1'b0, bsy, dn, dz, h, l);
      sawDone |= dn;
      sawBusy |= bsy;
    end
    checkEq("cancel_noDone", 64'(sawDone), 64'd0);
    checkEq("cancel_idle", 64'(sawBusy), 64'd0);
    checkEq("cancel_hi", h, 64'd0);
    checkEq("cancel_lo", l, 64'd1000000);

    // Reset in cycle 15 of an op: outputs clear at once, op is dropped.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, OP_DIVU, 64'd100, 64'd7);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, OP_DIVU, '0, '0);
    repeat (14) begin
      @(posedge clock); #1;
    end
    resetN = 1'b0;
    #1;
    sample(1'b0, bsy, dn, dz, h, l);
    checkEq("arst_busy", 64'(bsy), 64'd0);
    checkEq("arst_done", 64'(dn), 64'd0);
    checkEq("arst_dz", 64'(dz), 64'd0);
    checkEq("arst_hi", h, 64'd0);
    checkEq("arst_lo", l, 64'd0);
    @(posedge clock);
    @(posedge clock); #1;
    resetN = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      sample(1'b0, bsy, dn, dz, h, l);
      sawDone |= dn;
    end
    checkEq("arst_noDone", 64'(sawDone), 64'd0);

    // WIDTH=8 randomized, 500 ops per opcode, every 16th divisor forced to zero.
    for (int opc = 0; opc < 4; opc++) begin
      for (int i = 0; i < 500; i++) begin
        x = 64'($urandom_range(0, 255));
        y = (i % 16 == 0) ? 64'd0 : 64'($urandom_range(0, 255));
        if (i == 1) begin
          x = 64'h80;
          y = 64'hFF;
        end
        model(op_t'(opc), x, y, 8, eh, el, ed);
        lat = ed ? 2 : 11;
        runOp("rnd8", 1'b1, (i % 5 == 4), 1'b0, op_t'(opc), x, y, lat, eh, el, ed);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
